// File: rtl/mdu_exec_pkg.sv
// Shared types and constants for the execute-stage multiply/divide unit.
// Opcode encodings for MADD/MADDU/MSUB/MSUBU exist here in every build.
package mdu_exec_pkg;

  localparam int DIV_ITERS = 32;
  localparam int CNT_W     = $clog2(DIV_ITERS);

  typedef enum logic [3:0] {
    MULT  = 4'd0,
    MULTU = 4'd1,
    DIV   = 4'd2,
    DIVU  = 4'd3,
    MTHI  = 4'd4,
    MTLO  = 4'd5,
    MADD  = 4'd6,
    MADDU = 4'd7,
    MSUB  = 4'd8,
    MSUBU = 4'd9
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mdu_state_t;

  function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_exec_div_iter.sv
// Unsigned radix-2 restoring divider datapath: load latches the operands,
// each step retires one quotient bit. q_step/r_step show the post-step result.
module div_iter
  import mdu_exec_pkg::*;
(
  input  logic        clk,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] q_step,
  output logic [31:0] r_step
);

  logic [63:0] rq;
  logic [31:0] dvsr;
  logic [33:0] diff;
  logic        fits;

  // The partial remainder is shifted left before the compare, so it needs 33 bits.
  always_comb begin
    diff   = {1'b0, rq[63:31]} - {2'b00, dvsr};
    fits   = ~diff[33];
    r_step = fits ? diff[31:0] : rq[62:31];
    q_step = {rq[30:0], fits};
  end

  // NOTE: pure datapath registers are always loaded before use, so they carry no reset.
  always_ff @(posedge clk) begin
    if (load) begin
      rq   <= {32'd0, dividend};
      dvsr <= divisor;
    end else if (step) begin
      rq   <= {r_step, q_step};
    end
  end

endmodule

// File: rtl/mdu_exec.sv
// Execute-stage MDU with architectural HI/LO; iterative divide stalls EX.
// Define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU; otherwise they are no-ops.
module mdu_exec
  import mdu_exec_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  mdu_op_t     op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        stall_reqE_mdu,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  mdu_state_t       state, state_next;
  logic [CNT_W-1:0] count;
  logic             div_load, div_step, div_finish;
  logic             accept, is_div, is_signed;
  logic             mul_signed;
  logic [63:0]      product;
  logic             q_neg, r_neg, div_zero;
  logic [31:0]      dividend_raw;
  logic [31:0]      q_step, r_step;
  logic [31:0]      a_mag, b_mag;

  assign accept     = start && !flush && (state == IDLE);
  assign is_div     = (op == DIV) || (op == DIVU);
  assign is_signed  = (op == DIV);
  assign mul_signed = (op == MULT) || (op == MADD) || (op == MSUB);
  assign product    = {{32{mul_signed & src_a[31]}}, src_a} *
                      {{32{mul_signed & src_b[31]}}, src_b};
  assign a_mag      = neg_if(is_signed & src_a[31], src_a);
  assign b_mag      = neg_if(is_signed & src_b[31], src_b);
  assign busy       = (state == RUN);

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_next     = state;
    div_load       = 1'b0;
    div_step       = 1'b0;
    div_finish     = 1'b0;
    stall_reqE_mdu = 1'b0;
    case (state)
      IDLE: if (accept && is_div) begin
        stall_reqE_mdu = 1'b1;
        div_load       = 1'b1;
        state_next     = RUN;
      end
      RUN: if (flush) begin
        state_next = IDLE;
      end else begin
        stall_reqE_mdu = 1'b1;
        div_step       = 1'b1;
        if (count == CNT_W'(DIV_ITERS - 1)) begin
          div_finish = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      if (div_load)      count <= '0;
      else if (div_step) count <= count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (div_load) begin
      q_neg        <= is_signed & (src_a[31] ^ src_b[31]);
      r_neg        <= is_signed & src_a[31];
      div_zero     <= (src_b == 32'd0);
      dividend_raw <= src_a;
    end
  end

  div_iter u_div_iter (
    .clk      (clk),
    .load     (div_load),
    .step     (div_step),
    .dividend (a_mag),
    .divisor  (b_mag),
    .q_step   (q_step),
    .r_step   (r_step)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else if (div_finish) begin
      lo <= div_zero ? 32'hFFFF_FFFF : neg_if(q_neg, q_step);
      hi <= div_zero ? dividend_raw  : neg_if(r_neg, r_step);
    end else if (accept) begin
      case (op)
        MULT, MULTU: {hi, lo} <= product;
        MTHI:        hi <= src_a;
        MTLO:        lo <= src_a;
`ifdef MDU_MADD_EN
        MADD, MADDU: {hi, lo} <= {hi, lo} + product;
        MSUB, MSUBU: {hi, lo} <= {hi, lo} - product;
`endif
        default: ;
      endcase
    end
  end

endmodule
